// File: rtl/dmem_sramlike_if_if.sv
// Bus bundle for a sram-like data-memory port.
//   master : drives data_req, data_wr, data_size, data_addr and data_wdata;
//            receives data_addr_ok, data_data_ok and data_rdata.
//   slave  : the memory side, with the opposite directions.
interface dmem_sramlike_if_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_sramlike_if.sv
// Mem-stage adapter from the pipeline's load/store controls to a sram-like
// master bus. It issues one request per access, freezes the pipeline until the
// data phase completes, and keeps the load result while another stall source
// still holds the pipeline.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   memreadM/memwriteM load / store in the mem stage
//   excM              the access carries an exception and must not be issued
//   addrM, sizeM      virtual byte address, access size (0 byte, 1 half, 2/3 word)
//   signedM           sign-extend the load result
//   wdataM            right-aligned store data
//   stall_other       pipeline frozen by another source
//   mem_stall         freeze request from this block
//   rdataM            extended load result
//   bus               sram-like master (dmem_sramlike_if_if.master)
//
// state | meaning
// IDLE  | no transaction; request presented while an access is pending
// DATA  | address accepted, waiting for data_data_ok
// HOLD  | data returned but the pipeline is still frozen elsewhere; no reissue
module dmem_sramlike_if #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic        excM,
    input  logic [31:0] addrM,
    input  logic [1:0]  sizeM,
    input  logic        signedM,
    input  logic [31:0] wdataM,
    input  logic        stall_other,
    output logic        mem_stall,
    output logic [31:0] rdataM,
    dmem_sramlike_if_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        HOLD = 2'd2
    } stateT;

    stateT       state;
    stateT       curState;
    logic        access;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;
    logic [31:0] rdataQ;

    assign access = (memreadM | memwriteM) & ~excM;

    // While rst is high the outputs already behave as in IDLE, so a stale
    // DATA state cannot assert mem_stall before the reset edge.
    assign curState = rst ? IDLE : state;

    assign bus.data_wr   = memwriteM;
    assign bus.data_size = (sizeM == 2'd3) ? 2'd2 : sizeM;
    // kseg0 and kseg1 both map onto the low 512 MB of physical space.
    assign bus.data_addr = (KSEG_MAP && addrM[31:30] == 2'b10) ? {3'b000, addrM[28:0]} : addrM;

    always_comb begin
        case (sizeM)
            2'd0:    bus.data_wdata = {4{wdataM[7:0]}};
            2'd1:    bus.data_wdata = {2{wdataM[15:0]}};
            default: bus.data_wdata = wdataM;
        endcase
    end

    always_comb begin
        byteSel = bus.data_rdata[{addrM[1:0], 3'b000} +: 8];
        halfSel = addrM[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (sizeM)
            2'd0:    loadData = {{24{signedM & byteSel[7]}}, byteSel};
            2'd1:    loadData = {{16{signedM & halfSel[15]}}, halfSel};
            default: loadData = bus.data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rdataQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && bus.data_addr_ok) state <= DATA;
                end
                DATA: begin
                    if (bus.data_data_ok) begin
                        rdataQ <= loadData;
                        state  <= stall_other ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!stall_other) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.data_req = 1'b0;
        mem_stall    = 1'b0;
        rdataM       = rdataQ;
        case (curState)
            IDLE: begin
                bus.data_req = access;
                mem_stall    = access;
            end
            DATA: begin
                mem_stall = ~bus.data_data_ok;
                rdataM    = loadData;
            end
            default: ;
        endcase
        if (rst) rdataM = '0;
    end

endmodule

// File: tb/tb_dmem_sramlike_if.sv
module tb_dmem_sramlike_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM, excM, signedM, stall_other;
    logic [31:0] addrM, wdataM;
    logic [1:0]  sizeM;
    logic        mem_stall;
    logic [31:0] rdataM;

    always #5 clk = ~clk;

    dmem_sramlike_if_if bus ();

    dmem_sramlike_if #(.KSEG_MAP(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .excM       (excM),
        .addrM      (addrM),
        .sizeM      (sizeM),
        .signedM    (signedM),
        .wdataM     (wdataM),
        .stall_other(stall_other),
        .mem_stall  (mem_stall),
        .rdataM     (rdataM),
        .bus        (bus)
    );

    int nTests = 0;
    int nFail  = 0;
    int acceptCount = 0;
    logic [31:0] lastExp = '0;

    // Every accepted request (req & addr_ok at a non-reset edge) is one bus transaction.
    always @(posedge clk)
        if (!rst && bus.data_req && bus.data_addr_ok) acceptCount <= acceptCount + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] byteMask(input int nBytes);
        return (nBytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nBytes)) - 32'd1);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] size, input logic sgn);
        int nBytes, off;
        logic [31:0] mask, v;
        nBytes = sizeBytes(size);
        if (nBytes == 1)      off = int'(addr[1:0]);
        else if (nBytes == 2) off = addr[1] ? 2 : 0;
        else                  off = 0;
        mask = byteMask(nBytes);
        v = (rdata >> (8 * off)) & mask;
        if (sgn && nBytes < 4 && v[8 * nBytes - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] wdata, input logic [1:0] size);
        int nBytes;
        logic [31:0] w, r;
        nBytes = sizeBytes(size);
        w = wdata & byteMask(nBytes);
        r = '0;
        for (int i = 0; i < 4 / nBytes; i++) r = r | (w << (8 * nBytes * i));
        return r;
    endfunction

    function automatic logic [31:0] modelAddr(input logic [31:0] addr);
        return (addr[31:30] == 2'b10) ? (addr & 32'h1FFF_FFFF) : addr;
    endfunction

    // One complete load or store: addr_ok after addrWait request cycles, data_ok
    // dataWait cycles after the accepting cycle + 1, then hold cycles of HOLD.
    task automatic runTxn(input logic rd, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int addrWait, input int dataWait, input int hold, input string tag);
        logic [31:0] expRd;
        int acc0;
        expRd = modelLoad(rdata, addr, size, sgn);
        acc0 = acceptCount;
        memreadM = rd; memwriteM = ~rd; excM = 1'b0;
        addrM = addr; sizeM = size; signedM = sgn; wdataM = wdata; stall_other = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        for (int i = 0; i < addrWait; i++) begin
            @(negedge clk);
            chk1({tag, "/waitReq"}, bus.data_req, 1'b1);
            chk1({tag, "/waitStall"}, mem_stall, 1'b1);
            step();
        end
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk1({tag, "/req"}, bus.data_req, 1'b1);
        chk1({tag, "/reqStall"}, mem_stall, 1'b1);
        chk1({tag, "/wr"}, bus.data_wr, ~rd);
        chk({tag, "/size"}, 32'(bus.data_size), (size == 2'd3) ? 32'd2 : 32'(size));
        chk({tag, "/addr"}, bus.data_addr, modelAddr(addr));
        chk({tag, "/wdata"}, bus.data_wdata, modelWdata(wdata, size));
        step();
        for (int i = 0; i < dataWait; i++) begin
            bus.data_addr_ok = 1'($urandom_range(0, 1));
            stall_other = 1'($urandom_range(0, 1));
            excM = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk1({tag, "/dataReq"}, bus.data_req, 1'b0);
            chk1({tag, "/dataStall"}, mem_stall, 1'b1);
            step();
        end
        excM = 1'b0; bus.data_addr_ok = 1'b0;
        stall_other = (hold > 0);
        bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
        @(negedge clk);
        chk1({tag, "/okReq"}, bus.data_req, 1'b0);
        chk1({tag, "/okStall"}, mem_stall, 1'b0);
        chk({tag, "/okRdata"}, rdataM, expRd);
        step();
        bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        for (int i = 0; i < hold; i++) begin
            stall_other = (i < hold - 1);
            bus.data_addr_ok = 1'($urandom_range(0, 1));
            bus.data_data_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk1({tag, "/holdReq"}, bus.data_req, 1'b0);
            chk1({tag, "/holdStall"}, mem_stall, 1'b0);
            chk({tag, "/holdRdata"}, rdataM, expRd);
            step();
        end
        memreadM = 1'b0; memwriteM = 1'b0; stall_other = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1({tag, "/idleReq"}, bus.data_req, 1'b0);
        chk1({tag, "/idleStall"}, mem_stall, 1'b0);
        chk({tag, "/idleRdata"}, rdataM, expRd);
        chk({tag, "/txnCount"}, 32'(acceptCount), 32'(acc0 + 1));
        step();
        bus.data_data_ok = 1'b0;
        lastExp = expRd;
    endtask

    typedef struct {
        logic        rd, wr, exc;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        expReq, expStall, expWr;
        logic [1:0]  expSize;
        logic [31:0] expAddr, expWdata;
    } vecT;

    vecT vecs [8];

    initial begin
        logic [31:0] a;
        int acc0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'hA000_0002, 2'd1, 32'h0000_BEEF, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0002, 32'hBEEF_BEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h9FFF_FFF1, 2'd0, 32'h1234_56A5, 1'b1, 1'b1, 1'b1, 2'd0, 32'h1FFF_FFF1, 32'hA5A5_A5A5};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'hC000_0004, 2'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 2'd2, 32'hC000_0004, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h4000_0008, 2'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2'd2, 32'h4000_0008, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h8000_0000, 2'd2, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h1111_2222};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0000, 2'd1, 32'h0000_CAFE, 1'b0, 1'b0, 1'b0, 2'd1, 32'h1FC0_0000, 32'hCAFE_CAFE};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 2'd0, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0100, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h7FFF_FFFC, 2'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2'd0, 32'h7FFF_FFFC, 32'h0000_0000};

        rst = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; excM = 1'b0; signedM = 1'b0;
        stall_other = 1'b0; addrM = '0; wdataM = '0; sizeM = 2'd2;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;

        step();
        @(negedge clk);
        chk1("rst/req", bus.data_req, 1'b0);
        chk1("rst/stall", mem_stall, 1'b0);
        chk("rst/rdata", rdataM, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("postRst/stall", mem_stall, 1'b0);
        chk("postRst/rdata", rdataM, 32'h0);
        step();

        // Combinational bus fields in IDLE, addr_ok held low so nothing is accepted.
        for (int i = 0; i < 8; i++) begin
            memreadM = vecs[i].rd; memwriteM = vecs[i].wr; excM = vecs[i].exc;
            addrM = vecs[i].addr; sizeM = vecs[i].size; wdataM = vecs[i].wdata;
            @(negedge clk);
            chk1($sformatf("vec%0d/req", i), bus.data_req, vecs[i].expReq);
            chk1($sformatf("vec%0d/stall", i), mem_stall, vecs[i].expStall);
            chk1($sformatf("vec%0d/wr", i), bus.data_wr, vecs[i].expWr);
            chk($sformatf("vec%0d/size", i), 32'(bus.data_size), 32'(vecs[i].expSize));
            chk($sformatf("vec%0d/addr", i), bus.data_addr, vecs[i].expAddr);
            chk($sformatf("vec%0d/wdata", i), bus.data_wdata, vecs[i].expWdata);
            step();
        end
        memreadM = 1'b0; memwriteM = 1'b0; excM = 1'b0;

        // Load word through kseg0 with one idle data cycle.
        runTxn(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 0, 1, 0, "lw");
        @(negedge clk);
        chk("lw/const", rdataM, 32'h1234_5678);
        step();

        runTxn(1'b1, 32'h8000_0103, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC, 0, 0, 0, "lbs");
        @(negedge clk);
        chk("lbs/const", rdataM, 32'hFFFF_FF80);
        step();
        runTxn(1'b1, 32'h8000_0103, 2'd0, 1'b0, 32'h0, 32'h80AA_BBCC, 1, 0, 0, "lbu");
        @(negedge clk);
        chk("lbu/const", rdataM, 32'h0000_0080);
        step();

        runTxn(1'b0, 32'hA000_0002, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 0, 2, 0, "sh");
        runTxn(1'b1, 32'h0000_0040, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 0, 3, "hold");
        @(negedge clk);
        chk("hold/const", rdataM, 32'hCAFE_F00D);
        step();

        // Excepting load: no request, no stall, and addr_ok must not start a transaction.
        acc0 = acceptCount;
        memreadM = 1'b1; excM = 1'b1; addrM = 32'h0000_0080; sizeM = 2'd2;
        bus.data_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("exc/req", bus.data_req, 1'b0);
            chk1("exc/stall", mem_stall, 1'b0);
            step();
        end
        memreadM = 1'b0; excM = 1'b0; bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("exc/rdataKept", rdataM, lastExp);
        chk("exc/txnCount", 32'(acceptCount), 32'(acc0));
        step();
        bus.data_data_ok = 1'b0;

        // Reset while in DATA abandons the access; a late data_ok is ignored.
        runTxn(1'b1, 32'h0000_0004, 2'd1, 1'b1, 32'h0, 32'h7FFF_8001, 0, 0, 0, "preRst");
        memreadM = 1'b1; addrM = 32'h0000_0020; sizeM = 2'd2; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk1("rstSeq/req", bus.data_req, 1'b1);
        step();
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        chk1("rstSeq/dataStall", mem_stall, 1'b1);
        step();
        rst = 1'b1; memreadM = 1'b0;
        @(negedge clk);
        chk1("rstSeq/inRstStall", mem_stall, 1'b0);
        chk1("rstSeq/inRstReq", bus.data_req, 1'b0);
        chk("rstSeq/inRstRdata", rdataM, 32'h0);
        step();
        rst = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk1("rstSeq/lateStall", mem_stall, 1'b0);
        chk("rstSeq/lateRdata", rdataM, 32'h0);
        step();
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        chk("rstSeq/afterRdata", rdataM, 32'h0);
        step();
        runTxn(1'b1, 32'h0000_0024, 2'd2, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 0, 0, "postRstTxn");

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a[31:29] = 3'b100;
                1: a[31:29] = 3'b101;
                default: ;
            endcase
            runTxn(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
